// File: rtl/prog_ram.sv
// prog_ram: parametrised program/data RAM with a sequential valid/ready program loader.
// CPU side: combinational read (optionally masked to the operand field) and a
// clocked write. Loader side: i_ld_start arms a load at address 0, words then stream
// in one per accepted handshake until i_ld_last or the top address.
// Optional feature macro: PROG_RAM_CLEAR_ON_RESET_EN. When it is defined, reset enters a
// CLEAR sweep that zeroes every word (DEPTH cycles) before the CPU may use the array.
// OPERAND_WIDTH must be strictly less than DATA_WIDTH.

module prog_ram #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned OPERAND_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic                  i_operand,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_bus_data,
  output logic [DATA_WIDTH-1:0] o_bus_data,
  input  logic                  i_ld_start,
  input  logic                  i_ld_valid,
  input  logic                  i_ld_last,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  output logic                  o_ld_ready,
  output logic                  o_ld_done,
  output logic                  o_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Highest address; a load or clear sweep ends after writing it.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  // Keeps only the low operand field of a word.
  localparam logic [DATA_WIDTH-1:0] OPERAND_MASK =
      {{(DATA_WIDTH - OPERAND_WIDTH){1'b0}}, {OPERAND_WIDTH{1'b1}}};

`ifdef PROG_RAM_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {StIdle, StLoad, StClear} state_e;
  localparam state_e RESET_STATE = StClear;
`else
  typedef enum logic [1:0] {StIdle, StLoad} state_e;
  localparam state_e RESET_STATE = StIdle;
`endif

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    done_q, done_d;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_word;

  // No reset on the array: contents survive reset unless the clear sweep runs.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // State register: FSM state, load/clear pointer and the registered done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start a load from IDLE, advance the pointer on each write,
  // and return to IDLE after the final word (last flag or top address).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (i_ld_start) begin
          state_d = StLoad;
          ptr_d   = '0;
        end
      end
      StLoad: begin
        if (i_ld_valid) begin
          if (i_ld_last || (ptr_q == LAST_ADDR)) begin
            // Hold the pointer so it never wraps inside a load.
            state_d = StIdle;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
`ifdef PROG_RAM_CLEAR_ON_RESET_EN
      StClear: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  // Output logic: handshake/busy flags and selection of the single array write port.
  always_comb begin
    o_ld_ready = 1'b0;
    o_busy     = 1'b1;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = i_addr;
    mem_wdata  = i_bus_data;
    unique case (state_q)
      StIdle: begin
        o_busy = 1'b0;
        mem_we = i_we;
      end
      StLoad: begin
        // Ready depends only on state; no path from i_ld_valid.
        o_ld_ready = 1'b1;
        if (i_ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = i_ld_data;
          done_d    = i_ld_last || (ptr_q == LAST_ADDR);
        end
      end
`ifdef PROG_RAM_CLEAR_ON_RESET_EN
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
      end
`endif
      default: begin
        o_busy = 1'b1;
      end
    endcase
  end

  // Array write port; writes are suppressed while reset is held.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign o_ld_done = done_q;

  // Combinational read, blanked while the CPU is locked out.
  assign rd_word    = mem[i_addr];
  assign o_bus_data = o_busy    ? '0 :
                      i_operand ? (rd_word & OPERAND_MASK) :
                                  rd_word;

endmodule

// File: doc/prog_ram.md
# prog_ram

Parametrised program/data RAM for the CPU, the next generation of the 16×8 RAM, with configurable data, address and operand widths. It adds a sequential program loader that streams words in through a valid/ready handshake with an auto-incrementing address. Optionally, a hardware clear sweep zeroes the whole array after reset. It sits on the CPU bus between the memory address register and the bus mux, and it owns the front-panel/testbench program-load path.

## Interface
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.
- OPERAND_WIDTH, 4, low operand field of an instruction word; must be < DATA_WIDTH.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_we  in  1  CPU write enable; writes i_bus_data to mem[i_addr] at the clock edge.
- i_operand  in  1  operand read mode: o_bus_data upper DATA_WIDTH-OPERAND_WIDTH bits forced to 0.
- i_addr  in  ADDR_WIDTH  CPU read/write address.
- i_bus_data  in  DATA_WIDTH  CPU write data.
- o_bus_data  out  DATA_WIDTH  CPU read data, combinational.
- i_ld_start  in  1  start a program load from address 0.
- i_ld_valid  in  1  loader data valid.
- i_ld_last  in  1  qualifies i_ld_valid; marks the final word of the load.
- i_ld_data  in  DATA_WIDTH  loader word.
- o_ld_ready  out  1  loader can accept a word.
- o_ld_done  out  1  one-cycle pulse when a load completes.
- o_busy  out  1  high in CLEAR or LOAD; the CPU must hold off.

## Operation
- The FSM has three states: IDLE, CLEAR and LOAD. It has an ADDR_WIDTH-bit pointer ptr.
- **IDLE**
  - CPU reads and writes are active.
  - i_ld_start=1 moves the FSM to LOAD and sets ptr=0.
  - A CPU write on the same cycle as i_ld_start still happens.
- **LOAD**
  - o_ld_ready=1.
  - On i_ld_valid&o_ld_ready, mem[ptr] <= i_ld_data and ptr increments.
  - The load ends when i_ld_last is accepted or when ptr==DEPTH-1 is written (whichever comes first). The FSM then returns to IDLE and pulses o_ld_done on the next cycle.
  - ptr never wraps within a load.
  - i_ld_start is ignored while the FSM is not in IDLE.
- **CLEAR** (only when the macro is defined)
  - Writes mem[ptr] <= 0 each cycle with ptr incrementing, for DEPTH cycles.
  - After the write to DEPTH-1, the FSM enters IDLE.
  - Loader inputs are ignored.
- **While o_busy=1**
  - i_we is ignored.
  - o_bus_data is driven to 0.
- **Read path**
  - i_operand=0: o_bus_data = mem[i_addr].
  - i_operand=1: o_bus_data = {0, mem[i_addr][OPERAND_WIDTH-1:0]}.
  - The full ADDR_WIDTH of i_addr is decoded.
- **Reset values**
  - o_ld_ready=0, o_ld_done=0, ptr=0.
  - With the macro: state=CLEAR, o_busy=1.
  - Without the macro: state=IDLE, o_busy=0.
  - Reset does not touch the array directly.

## Timing
- **Read latency:** 0 cycles, combinational from i_addr/i_operand/state.
- **Write latency:** a CPU write is visible on o_bus_data in the cycle after the edge.
- **Load rate:** one word per cycle at sustained valid.
- **Load completion:** o_ld_done is asserted in the cycle following acceptance of the final word. o_busy and o_ld_ready fall in that same cycle.
- **Clear sweep:** takes exactly DEPTH cycles from reset deassertion. o_busy falls in cycle DEPTH.
- **Reset mid-LOAD:**
  - The load is aborted and no o_ld_done is produced.
  - Words already written are retained without the macro; with the macro they are zeroed by CLEAR.
- **Reset mid-CLEAR:** the sweep restarts at 0.
- **Backpressure:** o_ld_ready is a pure function of state, with no combinational path from i_ld_valid.

## Configuration
- Macro: PROG_RAM_CLEAR_ON_RESET_EN.
- Defined: reset enters CLEAR and the array reads 0 everywhere after DEPTH cycles.
- Undefined: the CLEAR state and its logic are omitted, reset goes straight to IDLE, and the array contents after power-up are undefined (X in simulation).

## Test plan
- **Operand read:** CPU writes 0xA7 to address 3. Read with i_operand=0 gives 0xA7; with i_operand=1 gives 0x07.
- **Full load:** i_ld_start, then 16 consecutive valid words 0x10..0x1F. Read-back gives mem[n]=0x10+n. o_ld_done pulses once, on the cycle after word 15, and o_busy falls.
- **Early terminate and backpressure:** load 0x55, 0x66, 0x77 with i_ld_last on the third word and i_ld_valid gapped by idle cycles. Only addresses 0-2 change. o_ld_done arrives one cycle after 0x77 is accepted.
- **Busy lockout:** i_we=1 to address 5 while in LOAD. mem[5] is written only by the loader, and o_bus_data=0 throughout LOAD.
- **Reset mid-load:** assert i_rst after 4 words.
  - No o_ld_done.
  - Macro defined: o_busy stays high 16 cycles, then all reads give 0.
  - Macro undefined: o_busy=0 immediately and words 0-3 are retained.
- **Parameter sweep:** DATA_WIDTH=16, ADDR_WIDTH=6, OPERAND_WIDTH=10. Load 64 words; the last accepted is address 63. Operand read of 0xFFFF gives 0x03FF.
